// File: rtl/dds_phase_recover_if.sv
// Valid/ready bundle between the sample stream and the recovered-phase consumer.
// With DDS_RESIDUAL_EN defined the bundle also carries the search residual.
interface dds_phase_recover_if;
   localparam int unsigned SAMPLE_W = 9;
   localparam int unsigned PHASE_W  = 8;

   logic [SAMPLE_W-1:0] in_sample;
   logic                in_valid;
   logic                in_ready;
   logic [PHASE_W-1:0]  out_phase;
   logic                out_valid;
   logic                out_ready;
`ifdef DDS_RESIDUAL_EN
   logic [PHASE_W-1:0]  out_residual;

   modport slave  (input  in_sample, in_valid, out_ready,
                   output in_ready, out_phase, out_valid, out_residual);
   modport master (output in_sample, in_valid, out_ready,
                   input  in_ready, out_phase, out_valid, out_residual);
`else
   modport slave  (input  in_sample, in_valid, out_ready,
                   output in_ready, out_phase, out_valid);
   modport master (output in_sample, in_valid, out_ready,
                   input  in_ready, out_phase, out_valid);
`endif
endinterface

// File: rtl/dds_phase_recover.sv
// Recovers the 8-bit DDS phase word from a 9-bit sine sample by binary search of the
// quarter-wave ROM. DDS_RESIDUAL_EN adds out_residual = mag - ROM[result].
module dds_phase_recover #(
   parameter int unsigned HYST = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   dds_phase_recover_if.slave bus
);
   localparam int unsigned MAG_W  = 8;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned CMP_W  = MAG_W + 1;

   localparam logic [MAG_W-1:0] ROM [64] = '{
      8'd0,   8'd6,   8'd13,  8'd19,  8'd25,  8'd31,  8'd37,  8'd44,
      8'd50,  8'd56,  8'd62,  8'd68,  8'd74,  8'd80,  8'd86,  8'd92,
      8'd98,  8'd103, 8'd109, 8'd115, 8'd120, 8'd126, 8'd131, 8'd136,
      8'd142, 8'd147, 8'd152, 8'd157, 8'd162, 8'd167, 8'd171, 8'd176,
      8'd180, 8'd185, 8'd189, 8'd193, 8'd197, 8'd201, 8'd205, 8'd208,
      8'd212, 8'd215, 8'd219, 8'd222, 8'd225, 8'd228, 8'd231, 8'd233,
      8'd236, 8'd238, 8'd240, 8'd242, 8'd244, 8'd246, 8'd247, 8'd249,
      8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255
   };

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_MAP, S_DONE} state_t;

   state_t              r_state,     w_state_nxt;
   logic                r_sign,      w_sign_nxt;
   logic [MAG_W-1:0]    r_mag,       w_mag_nxt;
   logic [ADDR_W-1:0]   r_result,    w_result_nxt;
   logic [BIT_W-1:0]    r_bit,       w_bit_nxt;
   logic [MAG_W-1:0]    r_prev_mag,  w_prev_mag_nxt;
   logic                r_prev_sign, w_prev_sign_nxt;
   logic                r_dir,       w_dir_nxt;
   logic [MAG_W-1:0]    r_out_phase, w_out_phase_nxt;
   logic                r_out_valid, w_out_valid_nxt;
   logic                r_in_ready,  w_in_ready_nxt;
   logic [MAG_W-1:0]    r_residual,  w_residual_nxt;

   logic [CMP_W-1:0]    w_neg, w_abs;
   logic [MAG_W-1:0]    w_in_mag;
   logic [ADDR_W-1:0]   w_cand, w_addr;
   logic [CMP_W-1:0]    w_mag9, w_prev9, w_hyst9;
   logic                w_pp;

   // Sign-magnitude of the incoming sample; only -256 reaches bit 8 and saturates.
   assign w_neg    = ~bus.in_sample + CMP_W'(1);
   assign w_abs    = bus.in_sample[CMP_W-1] ? w_neg : bus.in_sample;
   assign w_in_mag = w_abs[CMP_W-1] ? {MAG_W{1'b1}} : w_abs[MAG_W-1:0];

   assign w_cand  = r_result | ADDR_W'(1 << r_bit);
   assign w_mag9  = {1'b0, r_mag};
   assign w_prev9 = {1'b0, r_prev_mag};
   assign w_hyst9 = CMP_W'(HYST);

   always_comb begin
      w_state_nxt     = r_state;
      w_sign_nxt      = r_sign;
      w_mag_nxt       = r_mag;
      w_result_nxt    = r_result;
      w_bit_nxt       = r_bit;
      w_prev_mag_nxt  = r_prev_mag;
      w_prev_sign_nxt = r_prev_sign;
      w_dir_nxt       = r_dir;
      w_out_phase_nxt = r_out_phase;
      w_residual_nxt  = r_residual;
      w_pp            = 1'b0;
      w_addr          = '0;

      case (r_state)
         S_IDLE: begin
            if (bus.in_valid && r_in_ready) begin
               w_sign_nxt   = bus.in_sample[CMP_W-1];
               w_mag_nxt    = w_in_mag;
               w_result_nxt = '0;
               w_bit_nxt    = BIT_W'(ADDR_W - 1);
               w_state_nxt  = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (ROM[w_cand] <= r_mag) w_result_nxt = w_cand;
            if (r_bit == '0) w_state_nxt = S_MAP;
            else             w_bit_nxt   = r_bit - BIT_W'(1);
         end
         S_MAP: begin
            // Zero crossing forces rising; otherwise flip only on a trend beyond HYST.
            if (r_sign != r_prev_sign)            w_dir_nxt = 1'b0;
            else if (w_mag9 > w_prev9 + w_hyst9)  w_dir_nxt = 1'b0;
            else if (w_mag9 + w_hyst9 < w_prev9)  w_dir_nxt = 1'b1;

            if (r_mag == {MAG_W{1'b1}}) begin
               w_pp   = 1'b1;
               w_addr = '0;
            end else if (!w_dir_nxt) begin
               w_pp   = 1'b0;
               w_addr = r_result;
            end else begin
               w_pp   = 1'b1;
               w_addr = (r_result == '0) ? {ADDR_W{1'b1}} : ADDR_W'(0) - r_result;
            end
            w_out_phase_nxt = {r_sign, w_pp, w_addr};
            w_residual_nxt  = (r_mag == {MAG_W{1'b1}}) ? '0 : r_mag - ROM[r_result];
            w_prev_mag_nxt  = r_mag;
            w_prev_sign_nxt = r_sign;
            w_state_nxt     = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_in_ready_nxt  = (w_state_nxt == S_IDLE);
      w_out_valid_nxt = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sign      <= 1'b0;
         r_mag       <= '0;
         r_result    <= '0;
         r_bit       <= '0;
         r_prev_mag  <= '0;
         r_prev_sign <= 1'b0;
         r_dir       <= 1'b0;
         r_out_phase <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_residual  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sign      <= w_sign_nxt;
         r_mag       <= w_mag_nxt;
         r_result    <= w_result_nxt;
         r_bit       <= w_bit_nxt;
         r_prev_mag  <= w_prev_mag_nxt;
         r_prev_sign <= w_prev_sign_nxt;
         r_dir       <= w_dir_nxt;
         r_out_phase <= w_out_phase_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_residual  <= w_residual_nxt;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_phase = r_out_phase;
   assign bus.out_valid = r_out_valid;
`ifdef DDS_RESIDUAL_EN
   assign bus.out_residual = r_residual;
`else
   logic w_residual_unused;
   assign w_residual_unused = ^r_residual;
`endif

endmodule
